// File: rtl/dcache_pkg.sv
// Shared data-cache definitions: drain FSM states, default geometry and the drain opcode.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } flush_state_t;

    localparam int DEFAULT_NUM_LINES = 4;
    localparam int DEFAULT_LINE_BITS = 128;
    localparam int DEFAULT_ADDR_BITS = 32;

    localparam logic [6:0] DRAIN_OPCODE = 7'h7F;

endpackage

// File: rtl/dcache_flush_engine_if.sv
// Line-write bus between the drain engine (master) and main memory (slave).
interface dcache_flush_engine_if #(
    parameter int ADDR_BITS = dcache_pkg::DEFAULT_ADDR_BITS,
    parameter int LINE_BITS = dcache_pkg::DEFAULT_LINE_BITS
);
    logic                 mem_req;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [LINE_BITS-1:0] mem_wdata;
    logic                 mem_ready;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_wdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready
    );
endinterface

// File: rtl/dcache_flush_engine.sv
// Write-back drain engine: walks all cache lines and writes dirty ones to memory.
// Optional macro DCACHE_FLUSH_INVALIDATE_EN adds an invalidate output that empties the cache.
module dcache_flush_engine
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DEFAULT_NUM_LINES,
    parameter int LINE_BITS = DEFAULT_LINE_BITS,
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    localparam int INDEX_BITS  = $clog2(NUM_LINES),
    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8),
    localparam int TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush_req,
    output logic                  flush_busy,
    output logic                  flush_done,
    output logic [INDEX_BITS-1:0] line_idx,
    input  logic                  line_valid,
    input  logic                  line_dirty,
    input  logic [TAG_BITS-1:0]   line_tag,
    input  logic [LINE_BITS-1:0]  line_data,
    output logic                  clear_dirty,
`ifdef DCACHE_FLUSH_INVALIDATE_EN
    output logic                  invalidate,
`endif
    dcache_flush_engine_if.master mem,
    output logic [INDEX_BITS:0]   lines_written
);

    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(NUM_LINES - 1);

    flush_state_t          state_r;
    flush_state_t          state_nxt_s;
    logic [INDEX_BITS-1:0] idx_r;
    logic [INDEX_BITS-1:0] idx_nxt_s;
    logic                  pending_r;
    logic                  pending_nxt_s;
    logic [INDEX_BITS:0]   written_r;
    logic [INDEX_BITS:0]   written_nxt_s;
    logic [ADDR_BITS-1:0]  addr_r;
    logic [LINE_BITS-1:0]  wdata_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  req_r;
    logic                  latch_s;
    logic                  clear_s;
    logic                  last_s;

    assign last_s = (idx_r == LAST_IDX);

    // Next-state, line walk and write-completion decode.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        pending_nxt_s = pending_r;
        written_nxt_s = written_r;
        latch_s       = 1'b0;
        clear_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (flush_req) begin
                    state_nxt_s   = SCAN;
                    idx_nxt_s     = '0;
                    written_nxt_s = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                pending_nxt_s = pending_r | flush_req;
                if (line_valid && line_dirty) begin
                    state_nxt_s = WRITE;
                    latch_s     = 1'b1;
                end else if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    idx_nxt_s = idx_r + INDEX_BITS'(1);
                end
            end
            WRITE: begin
                pending_nxt_s = pending_r | flush_req;
                if (mem.mem_ready) begin
                    clear_s       = 1'b1;
                    written_nxt_s = written_r + (INDEX_BITS+1)'(1);
                    if (last_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = SCAN;
                        idx_nxt_s   = idx_r + INDEX_BITS'(1);
                    end
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            DONE: begin
                // A request arriving in DONE is folded into the pending restart.
                idx_nxt_s     = '0;
                pending_nxt_s = 1'b0;
                if (pending_r || flush_req) begin
                    state_nxt_s   = SCAN;
                    written_nxt_s = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                idx_nxt_s     = '0;
                pending_nxt_s = 1'b0;
            end
        endcase
    end

    // State, walk counter and registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            pending_r <= 1'b0;
            written_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            req_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            pending_r <= pending_nxt_s;
            written_r <= written_nxt_s;
            busy_r    <= (state_nxt_s != IDLE);
            done_r    <= (state_nxt_s == DONE);
            req_r     <= (state_nxt_s == WRITE);
        end
    end

    // Write address and data are captured once and held until memory accepts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (latch_s) begin
            addr_r  <= {line_tag, idx_r, {OFFSET_BITS{1'b0}}};
            wdata_r <= line_data;
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // clear_dirty must coincide with the accepting cycle while line_idx still points at the line.
    assign clear_dirty   = clear_s;
    assign flush_busy    = busy_r;
    assign flush_done    = done_r;
    assign line_idx      = idx_r;
    assign lines_written = written_r;
    assign mem.mem_req   = req_r;
    assign mem.mem_addr  = addr_r;
    assign mem.mem_wdata = wdata_r;

`ifdef DCACHE_FLUSH_INVALIDATE_EN
    // Written lines and valid clean lines are both dropped as the walk passes them.
    always_comb begin
        invalidate = clear_s | ((state_r == SCAN) & line_valid & ~line_dirty);
    end
`endif

endmodule

// File: tb/tb_dcache_flush_engine.sv
// Scoreboard bench for dcache_flush_engine with a 4-line behavioural cache model.
module tb_dcache_flush_engine;
    import dcache_pkg::*;

    localparam int NL = 4;
    localparam int LB = 128;
    localparam int AB = 32;
    localparam int IB = 2;
    localparam int TB = 26;

    typedef struct { logic [AB-1:0] addr; logic [LB-1:0] data; } wr_t;
    typedef struct { int cyc; int wr; } dn_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          flush_req = 1'b0;
    logic          mem_ready_tb = 1'b1;
    logic          flush_busy, flush_done, clear_dirty;
    logic [IB-1:0] line_idx;
    logic          line_valid, line_dirty;
    logic [TB-1:0] line_tag;
    logic [LB-1:0] line_data;
    logic [IB:0]   lines_written;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
    logic          invalidate;
    logic [NL-1:0] inv_mask = '0;
`endif

    logic [TB-1:0] tag_tab [NL] = '{26'h0123456, 26'h3FFFFFF, 26'h2AAAAAA, 26'h0000001};
    logic [LB-1:0] data_tab [NL] = '{128'h00000000_11111111_22222222_33333333,
                                     128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF,
                                     128'hA5A5A5A5_5A5A5A5A_FFFF0000_0000FFFF,
                                     128'h80000000_00000000_00000000_00000001};
    logic [AB-1:0] exp_addr [NL] = '{32'h048D1580, 32'hFFFFFFD0, 32'hAAAAAAA0, 32'h00000070};

    logic [NL-1:0] v_r = '0;
    logic [NL-1:0] d_r = '0;
    logic [NL-1:0] ld_v = '0;
    logic [NL-1:0] ld_d = '0;
    logic          load = 1'b0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            clr_cnt = 0;
    wr_t           exp_wr [$];
    dn_t           exp_dn [$];

    always #5 clock = ~clock;

    dcache_flush_engine_if #(.ADDR_BITS(AB), .LINE_BITS(LB)) mem_bus ();
    assign mem_bus.mem_ready = mem_ready_tb;

    dcache_flush_engine #(.NUM_LINES(NL), .LINE_BITS(LB), .ADDR_BITS(AB)) dut (
        .clock         (clock),
        .reset         (reset),
        .flush_req     (flush_req),
        .flush_busy    (flush_busy),
        .flush_done    (flush_done),
        .line_idx      (line_idx),
        .line_valid    (line_valid),
        .line_dirty    (line_dirty),
        .line_tag      (line_tag),
        .line_data     (line_data),
        .clear_dirty   (clear_dirty),
`ifdef DCACHE_FLUSH_INVALIDATE_EN
        .invalidate    (invalidate),
`endif
        .mem           (mem_bus.master),
        .lines_written (lines_written)
    );

    assign line_valid = v_r[line_idx];
    assign line_dirty = d_r[line_idx];
    assign line_tag   = tag_tab[line_idx];
    assign line_data  = data_tab[line_idx];

    // Cache model: pattern loads, dirty clears and invalidations.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (load) begin
            v_r <= ld_v;
            d_r <= ld_d;
        end else if (reset) begin
            if (clear_dirty) d_r[line_idx] <= 1'b0;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
            if (invalidate) v_r[line_idx] <= 1'b0;
`endif
        end
    end

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_lines(input logic [NL-1:0] v, input logic [NL-1:0] d);
        @(posedge clock); #1;
        ld_v = v; ld_d = d; load = 1'b1;
        @(posedge clock); #1;
        load = 1'b0;
    endtask

    task automatic pulse_req(output int rq);
        @(posedge clock); #1;
        flush_req = 1'b1;
        rq = cyc;
        @(posedge clock); #1;
        flush_req = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int t = 0;
        while ((exp_dn.size() != 0 || flush_busy) && t < max) begin
            @(negedge clock);
            t++;
        end
        chk("drain_complete", exp_dn.size(), 0);
    endtask

    task automatic push_wr(input int i);
        wr_t w;
        w.addr = exp_addr[i];
        w.data = data_tab[i];
        exp_wr.push_back(w);
    endtask

    task automatic push_dn(input int c, input int n);
        dn_t d;
        d.cyc = c;
        d.wr  = n;
        exp_dn.push_back(d);
    endtask

    initial begin
        int rq;
        int c0;
        fork
            forever begin
                wr_t w;
                dn_t d;
                @(negedge clock);
                if (reset) begin
                    if (mem_bus.mem_req && mem_bus.mem_ready) begin
                        if (exp_wr.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_write: actual addr=%0h expected no write", mem_bus.mem_addr);
                        end else begin
                            w = exp_wr.pop_front();
                            chk("wr_addr", mem_bus.mem_addr, w.addr);
                            chk("wr_data", mem_bus.mem_wdata, w.data);
                        end
                    end
                    if (flush_done) begin
                        if (exp_dn.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_done: actual cycle=%0d expected no done", cyc);
                        end else begin
                            d = exp_dn.pop_front();
                            chk("done_cycle", cyc, d.cyc);
                            chk("done_lines_written", lines_written, d.wr);
                        end
                    end
                    if (clear_dirty) clr_cnt++;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
                    if (invalidate) inv_mask[line_idx] = 1'b1;
`endif
                end
            end
        join_none

        #12;
        chk("rst_busy", flush_busy, 0);
        chk("rst_done", flush_done, 0);
        chk("rst_req", mem_bus.mem_req, 0);
        chk("rst_clear", clear_dirty, 0);
        chk("rst_idx", line_idx, 0);
        chk("rst_written", lines_written, 0);
        chk("rst_addr", mem_bus.mem_addr, 0);
        chk("rst_wdata", mem_bus.mem_wdata, 0);
        #10;
        reset = 1'b1;

`ifndef DCACHE_FLUSH_INVALIDATE_EN
        // Lines 0 and 2 dirty, zero-wait memory.
        set_lines(4'b0111, 4'b0101);
        c0 = clr_cnt;
        pulse_req(rq);
        push_wr(0); push_wr(2); push_dn(rq + 7, 2);
        wait_idle(40);
        repeat (3) @(negedge clock);
        chk("written_hold", lines_written, 2);
        chk("clear_count_a", clr_cnt - c0, 2);
        chk("dirty_after_a", d_r, 4'b0000);

        // All lines clean: no writes at all.
        set_lines(4'b1111, 4'b0000);
        c0 = clr_cnt;
        pulse_req(rq);
        push_dn(rq + 5, 0);
        wait_idle(40);
        chk("clear_count_b", clr_cnt - c0, 0);

        // Line 3 dirty with three wait cycles on memory.
        set_lines(4'b1000, 4'b1000);
        c0 = clr_cnt;
        mem_ready_tb = 1'b0;
        pulse_req(rq);
        push_wr(3); push_dn(rq + 9, 1);
        for (int t = 0; t < 20 && !mem_bus.mem_req; t++) @(negedge clock);
        chk("write_reached", mem_bus.mem_req, 1);
        for (int k = 0; k < 4; k++) begin
            chk("stall_req", mem_bus.mem_req, 1);
            chk("stall_addr", mem_bus.mem_addr, 32'h00000070);
            chk("stall_data", mem_bus.mem_wdata, data_tab[3]);
            if (k < 3) begin
                @(posedge clock); #1;
                if (k == 2) mem_ready_tb = 1'b1;
                @(negedge clock);
            end
        end
        wait_idle(40);
        chk("clear_count_c", clr_cnt - c0, 1);

        // Two extra requests during a drain collapse into one follow-up drain.
        set_lines(4'b0001, 4'b0001);
        pulse_req(rq);
        push_wr(0); push_dn(rq + 6, 1); push_dn(rq + 11, 0);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            chk("busy_between_drains", flush_busy, (i <= 11) ? 1'b1 : 1'b0);
            @(posedge clock); #1;
            flush_req = (i + 1 == 2 || i + 1 == 4);
        end
        flush_req = 1'b0;
        wait_idle(40);

        // Reset asserted while a write is stalled.
        set_lines(4'b0010, 4'b0010);
        mem_ready_tb = 1'b0;
        pulse_req(rq);
        for (int t = 0; t < 20 && !mem_bus.mem_req; t++) @(negedge clock);
        chk("rst_write_reached", mem_bus.mem_req, 1);
        @(posedge clock); #2;
        reset = 1'b0;
        mem_ready_tb = 1'b1;
        #1;
        chk("arst_req", mem_bus.mem_req, 0);
        chk("arst_busy", flush_busy, 0);
        chk("arst_clear", clear_dirty, 0);
        chk("arst_done", flush_done, 0);
        @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("idle_after_reset", flush_busy, 0);
        end
        chk("dirty_kept", d_r, 4'b0010);
`else
        // Dirty, valid-clean, invalid, dirty: all valid lines end up invalidated.
        set_lines(4'b1011, 4'b1001);
        inv_mask = '0;
        c0 = clr_cnt;
        pulse_req(rq);
        push_wr(0); push_wr(3); push_dn(rq + 7, 2);
        wait_idle(40);
        chk("inv_mask", inv_mask, 4'b1011);
        chk("inv_valid_after", v_r, 4'b0000);
        chk("inv_clear_count", clr_cnt - c0, 2);
`endif

        chk("writes_consumed", exp_wr.size(), 0);
        chk("dones_consumed", exp_dn.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_flush_engine.md
Name: dcache_flush_engine

Overview:
- Parametrised write-back drain engine for the data cache. It replaces the single hard-wired drain path behind the special drain instruction (opcode 0x7F).
- Walks every cache line, writes each valid and dirty line to main memory over a request/ready handshake, then clears the line's dirty bit.
- Sits beside the MEM-stage cache. The pipeline stalls on flush_busy.

Parameters:
- NUM_LINES, 4, number of cache lines walked; power of two, ≥2.
- LINE_BITS, 128, cache line width in bits; power of two, ≥32.
- ADDR_BITS, 32, byte-address width on the memory side.
- Derived, not overridable: INDEX_BITS = $clog2(NUM_LINES); OFFSET_BITS = $clog2(LINE_BITS/8); TAG_BITS = ADDR_BITS − INDEX_BITS − OFFSET_BITS.

Ports:
- clock, in, 1, system clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- flush_req, in, 1, drain request; asserted by decode of opcode 0x7F.
- flush_busy, out, 1, engine active; pipeline stall.
- flush_done, out, 1, one-cycle pulse when a drain completes.
- line_idx, out, INDEX_BITS, index of the cache line being inspected.
- line_valid, in, 1, valid bit of line_idx (combinational cache read).
- line_dirty, in, 1, dirty bit of line_idx.
- line_tag, in, TAG_BITS, tag of line_idx.
- line_data, in, LINE_BITS, data of line_idx.
- clear_dirty, out, 1, one-cycle pulse; cache clears the dirty bit of line_idx.
- mem_req, out, 1, memory write request.
- mem_addr, out, ADDR_BITS, line-aligned byte address.
- mem_wdata, out, LINE_BITS, line data to write.
- mem_ready, in, 1, memory accepts the write this cycle.
- lines_written, out, INDEX_BITS+1, count of lines written by the last drain.

Behaviour:
- Reset (asynchronous, reset low):
  - State goes to IDLE; line_idx = 0; pending = 0; lines_written = 0.
  - All outputs are 0 while reset is low.
  - Reset asserted mid-drain immediately drops mem_req. Memory must tolerate an abandoned request. Dirty bits of unwritten lines stay set.
- IDLE:
  - flush_req = 1 → SCAN next cycle, with line_idx = 0 and lines_written = 0.
  - flush_busy rises in that same next cycle.
- SCAN, one line per cycle:
  - If line_valid and line_dirty → WRITE, latching tag and data into output registers.
  - Else, if line_idx == NUM_LINES−1 → DONE.
  - Else line_idx increments.
- WRITE:
  - mem_req = 1; mem_addr = {tag, line_idx, OFFSET_BITS zeros}; mem_wdata = latched data.
  - All three outputs are held stable until mem_ready.
  - In the cycle mem_ready = 1: clear_dirty pulses and lines_written increments.
  - Next state is DONE if line_idx == NUM_LINES−1, else SCAN with line_idx + 1.
  - mem_ready already high in the first WRITE cycle gives a 1-cycle write.
  - mem_ready outside WRITE is ignored.
- DONE:
  - flush_done = 1 for exactly one cycle; flush_busy is still 1.
  - Next state is SCAN with a fresh drain if pending = 1 (pending then cleared), else IDLE.
- flush_busy = 1 in SCAN, WRITE and DONE.
- Latency for D dirty lines with zero-wait memory: flush_done appears NUM_LINES + D + 1 cycles after the flush_req cycle.
- flush_req while busy sets pending. Multiple requests collapse into a single extra drain.
- line_idx wraps only via DONE, never via counter overflow.
- lines_written holds its value after DONE until the next drain starts.
- An empty cache (no dirty lines) still completes: NUM_LINES SCAN cycles, then DONE.

Optional Feature:
- Macro: DCACHE_FLUSH_INVALIDATE_EN.
- Defined: adds output invalidate (1 bit), pulsed together with clear_dirty. Also pulsed during SCAN for each valid, clean line, so that after DONE the whole cache is invalid.
- Undefined: the port does not exist; lines stay valid and clean after the drain.

Decomposition:
- Package dcache_pkg holds:
  - the flush_state_t enum {IDLE, SCAN, WRITE, DONE};
  - the default LINE_BITS / NUM_LINES constants shared with the cache and main memory;
  - the DRAIN_OPCODE = 7'h7F constant.
- No sub-module: the single FSM with its datapath registers fits in one module.

Test Plan:
- NUM_LINES=4, lines 0 and 2 dirty, mem_ready tied high, single flush_req pulse → two writes, to addresses {tag0,2'd0,4'h0} and {tag2,2'd2,4'h0} with matching data; flush_done 7 cycles after the request; lines_written = 2.
- All lines clean → no mem_req; flush_done 5 cycles after the request; lines_written = 0.
- Line 3 dirty, mem_ready delayed 3 cycles → mem_req, mem_addr and mem_wdata stable over 4 cycles; a single clear_dirty pulse; flush_done next cycle.
- flush_req re-pulsed twice during a drain → exactly one extra drain follows DONE; flush_busy does not drop between the two drains.
- reset driven low while in WRITE with mem_ready low → mem_req, flush_busy, clear_dirty all 0 asynchronously; IDLE after release; no flush_done.
- DCACHE_FLUSH_INVALIDATE_EN defined, lines {0 dirty, 1 valid clean, 2 invalid, 3 dirty} → invalidate pulses for lines 0, 1 and 3; 2 memory writes.
